// File: rtl/vga_text_controller_pkg.sv
// Shared constants, FSM state type and address helper for the VGA text
// controller slice.
//   COLS/ROWS         : text grid (8x8-pixel cells)
//   H_VISIBLE/H_TOTAL : horizontal timing in pixels
//   V_TOTAL           : lines per frame
//   ADDR_W/CELLS      : character buffer address width and depth
//   FETCH_PHASE       : pixel phase within a cell reserved for display fetch
package vga_text_pkg;

  localparam int COLS      = 80;
  localparam int ROWS      = 60;
  localparam int H_VISIBLE = 640;
  localparam int H_TOTAL   = 800;
  localparam int V_TOTAL   = 525;
  localparam int ADDR_W    = 13;
  localparam int CELLS     = COLS * ROWS;

  localparam logic [2:0] FETCH_PHASE = 3'd6;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP,
    CLEAR
  } state_t;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [6:0] row,
                                                  input logic [7:0] col);
    return ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/vga_text_controller_text_buffer_ram.sv
// Single-port character buffer, CELLS x 8, synchronous read (1-cycle latency).
//   clk   : clock
//   addr  : cell address
//   we    : write enable
//   wdata : write data
//   q     : registered read data for the address of the previous cycle
module text_buffer_ram
  import vga_text_pkg::*;
(
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [7:0]        wdata,
  output logic [7:0]        q
);

  logic [7:0] mem [CELLS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    q <= mem[addr];
  end

endmodule

// File: rtl/vga_text_controller.sv
// VGA text controller: arbitrates the single character-buffer port between
// the display fetch (owns every phase-6 cycle) and the host req/ack port,
// and runs a background full-screen fill.
//   pixel_clock, reset_n      : clock, synchronous active-low reset
//   vga_hpos, vga_vpos        : current beam position
//   character                 : glyph code for the cell being drawn
//   host_req/we/addr/wdata    : host access request (held until host_ack)
//   host_rdata, host_ack      : read data and one-cycle completion pulse
//   clear_start, clear_char   : launch a fill of every cell with clear_char
//   clear_busy                : fill in progress
module vga_text_controller
  import vga_text_pkg::*;
(
  input  logic              pixel_clock,
  input  logic              reset_n,
  input  logic [10:0]       vga_hpos,
  input  logic [9:0]        vga_vpos,
  output logic [7:0]        character,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata,
  output logic              host_ack,
  input  logic              clear_start,
  input  logic [7:0]        clear_char,
  output logic              clear_busy
);

  localparam logic [10:0]       H_FETCH_END = 11'(H_VISIBLE - 8);
  localparam logic [10:0]       H_NEXT_LINE = 11'(H_TOTAL - 2);
  localparam logic [9:0]        V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [ADDR_W-1:0] CELL_LAST   = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W-1:0] CELL_COUNT  = ADDR_W'(CELLS);

  state_t            state, state_n;
  logic              slot;
  logic              fetch_on, fetch_valid, fetch_d;
  logic [6:0]        fetch_row;
  logic [7:0]        fetch_col;
  logic [ADDR_W-1:0] fetch_addr;
  logic              host_in_range;
  logic              grant_host, grant_clear;
  logic              acc_we, acc_oor;
  logic [ADDR_W-1:0] clr_cnt;
  logic [7:0]        fill_char;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [7:0]        ram_wdata, ram_q;

  assign slot          = (vga_hpos[2:0] == FETCH_PHASE);
  assign host_in_range = (host_addr < CELL_COUNT);

  // Fetch one cell ahead; the phase-6 slot near end of line prefetches column 0
  // of the following line. Rows past the grid (vertical blanking) are skipped
  // so the glyph register never loads undefined buffer data.
  always_comb begin
    fetch_on  = 1'b0;
    fetch_row = vga_vpos[9:3];
    fetch_col = vga_hpos[10:3] + 8'd1;
    if (vga_hpos < H_FETCH_END) begin
      fetch_on = 1'b1;
    end else if (vga_hpos == H_NEXT_LINE) begin
      fetch_on  = 1'b1;
      fetch_row = (vga_vpos == V_LAST) ? 7'd0 : 7'((vga_vpos + 10'd1) >> 3);
      fetch_col = 8'd0;
    end
    fetch_valid = slot && fetch_on && (fetch_row < 7'(ROWS));
    fetch_addr  = cell_addr(fetch_row, fetch_col);
  end

  always_ff @(posedge pixel_clock) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state and RAM port ownership; slot cycles always leave the port
  // with the display fetch (read-only).
  always_comb begin
    state_n     = state;
    ram_addr    = fetch_addr;
    ram_we      = 1'b0;
    ram_wdata   = host_wdata;
    grant_host  = 1'b0;
    grant_clear = 1'b0;
    case (state)
      IDLE: begin
        if (!slot) begin
          if (clear_start) begin
            grant_clear = 1'b1;
            state_n     = CLEAR;
          end else if (host_req) begin
            grant_host = 1'b1;
            ram_addr   = host_addr;
            ram_we     = host_we && host_in_range;
            state_n    = ACCESS;
          end
        end
      end
      ACCESS: state_n = RESP;
      RESP:   state_n = IDLE;
      CLEAR: begin
        if (!slot) begin
          ram_addr  = clr_cnt;
          ram_we    = 1'b1;
          ram_wdata = fill_char;
          if (clr_cnt == CELL_LAST) begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // An aborting reset must not let the in-flight write land.
    if (!reset_n) begin
      ram_we = 1'b0;
    end
  end

  always_ff @(posedge pixel_clock) begin
    if (!reset_n) begin
      character  <= 8'h20;
      host_ack   <= 1'b0;
      host_rdata <= '0;
      clear_busy <= 1'b0;
      fetch_d    <= 1'b0;
      acc_we     <= 1'b0;
      acc_oor    <= 1'b0;
      clr_cnt    <= '0;
      fill_char  <= '0;
    end else begin
      fetch_d <= fetch_valid;
      if (fetch_d) begin
        character <= ram_q;
      end

      host_ack <= (state == ACCESS);
      if (grant_host) begin
        acc_we  <= host_we;
        acc_oor <= !host_in_range;
      end
      if (state == ACCESS) begin
        if (acc_oor) begin
          host_rdata <= '0;
        end else if (!acc_we) begin
          host_rdata <= ram_q;
        end
      end

      if (grant_clear) begin
        fill_char  <= clear_char;
        clr_cnt    <= '0;
        clear_busy <= 1'b1;
      end else if (state == CLEAR && !slot) begin
        clr_cnt <= clr_cnt + ADDR_W'(1);
        if (clr_cnt == CELL_LAST) begin
          clear_busy <= 1'b0;
        end
      end
    end
  end

  text_buffer_ram u_ram (
    .clk   (pixel_clock),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

endmodule

// File: tb/tb_vga_text_controller.sv
module tb_vga_text_controller;
  import vga_text_pkg::*;

  logic              pixel_clock = 1'b0;
  logic              reset_n;
  logic [10:0]       vga_hpos;
  logic [9:0]        vga_vpos;
  logic [7:0]        character;
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [7:0]        host_wdata;
  logic [7:0]        host_rdata;
  logic              host_ack;
  logic              clear_start;
  logic [7:0]        clear_char;
  logic              clear_busy;

  vga_text_controller dut (
    .pixel_clock (pixel_clock),
    .reset_n     (reset_n),
    .vga_hpos    (vga_hpos),
    .vga_vpos    (vga_vpos),
    .character   (character),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_rdata  (host_rdata),
    .host_ack    (host_ack),
    .clear_start (clear_start),
    .clear_char  (clear_char),
    .clear_busy  (clear_busy)
  );

  always #5 pixel_clock = ~pixel_clock;

  typedef struct {
    logic [7:0] rdata;
    bit         chk;
    int         lat;
    int         start;
    int         tag;
  } host_exp_t;

  typedef struct {
    int         h;
    int         v;
    logic [7:0] ch;
  } char_exp_t;

  host_exp_t hq[$];
  char_exp_t cq[$];

  int vectors  = 0;
  int fails    = 0;
  int cyc      = 0;
  int busy_cnt = 0;
  int tag_n    = 0;
  int jump_seq = 0;
  int jh       = 0;
  int jv       = 0;

  function automatic void check(input string name, input int tag,
                                input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, tag, act, exp);
    end
  endfunction

  // Beam position source; can be jumped to skip most of a frame.
  initial begin : timing_gen
    int seen;
    seen     = 0;
    vga_hpos = '0;
    vga_vpos = '0;
    forever begin
      @(posedge pixel_clock);
      #1;
      if (jump_seq != seen) begin
        seen     = jump_seq;
        vga_hpos = 11'(jh);
        vga_vpos = 10'(jv);
      end else if (vga_hpos == 11'(H_TOTAL - 1)) begin
        vga_hpos = '0;
        vga_vpos = (vga_vpos == 10'(V_TOTAL - 1)) ? '0 : vga_vpos + 10'd1;
      end else begin
        vga_hpos = vga_hpos + 11'd1;
      end
    end
  end

  always @(posedge pixel_clock) cyc++;
  always @(negedge pixel_clock) if (clear_busy === 1'b1) busy_cnt++;

  // Monitor: host responses and display characters.
  always @(negedge pixel_clock) begin
    host_exp_t e;
    if (reset_n === 1'b1 && host_ack === 1'b1) begin
      if (hq.size() == 0) begin
        vectors++;
        fails++;
        $display("FAIL unexpected_ack: got ack with no request outstanding");
      end else begin
        e = hq.pop_front();
        if (e.chk) check("host_rdata", e.tag, 32'(host_rdata), 32'(e.rdata));
        if (e.lat >= 0) check("host_latency", e.tag, cyc - e.start, e.lat);
        check("busy_at_ack", e.tag, 32'(clear_busy), 32'd0);
      end
    end
    if (cq.size() > 0 && int'(vga_hpos) == cq[0].h && int'(vga_vpos) == cq[0].v) begin
      check("character", cq[0].v * 1000 + cq[0].h, 32'(character), 32'(cq[0].ch));
      void'(cq.pop_front());
    end
  end

  task automatic step();
    @(posedge pixel_clock);
    #2;
  endtask

  task automatic jump_to(input int h, input int v);
    jh = h;
    jv = v;
    jump_seq++;
    step();
  endtask

  task automatic push_char(input int v, input int h, input logic [7:0] ch);
    char_exp_t c;
    c.v = v; c.h = h; c.ch = ch;
    cq.push_back(c);
  endtask

  task automatic issue(input bit we, input int addr, input logic [7:0] wd,
                       input logic [7:0] exp, input bit chk, input bit lat_known);
    host_exp_t e;
    host_we    = we;
    host_addr  = ADDR_W'(addr);
    host_wdata = wd;
    host_req   = 1'b1;
    e.rdata = exp;
    e.chk   = chk;
    e.start = cyc;
    e.tag   = tag_n;
    tag_n++;
    if (!lat_known) e.lat = -1;
    else e.lat = (vga_hpos[2:0] == FETCH_PHASE) ? 3 : 2;
    hq.push_back(e);
  endtask

  task automatic wait_ack(input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge pixel_clock);
      if (host_ack === 1'b1) begin
        host_req = 1'b0;
        seen     = 1'b1;
      end
    end
    if (!seen) begin
      vectors++;
      fails++;
      $display("FAIL ack_timeout[%0d]: got no ack, expected ack within %0d cycles", tag_n - 1, limit);
      host_req = 1'b0;
      if (hq.size() > 0) void'(hq.pop_back());
    end
  endtask

  task automatic host_op(input bit we, input int addr, input logic [7:0] wd,
                         input logic [7:0] exp, input bit chk);
    step();
    issue(we, addr, wd, exp, chk, 1'b1);
    wait_ack(40);
  endtask

  task automatic wait_chars(input int limit);
    for (int i = 0; i < limit && cq.size() > 0; i++) @(negedge pixel_clock);
    if (cq.size() > 0) begin
      vectors++;
      fails++;
      $display("FAIL char_timeout: got %0d unchecked cells, expected 0", cq.size());
      cq.delete();
    end
  endtask

  task automatic align_nonslot();
    while (vga_hpos[2:0] == FETCH_PHASE) step();
  endtask

  // Cycles the fill stays busy, given the pixel phase of its first cycle.
  function automatic int clear_model(input int p0);
    int p, w, n;
    p = p0; w = 0; n = 0;
    while (w < CELLS) begin
      n++;
      if (p != 6) w++;
      p = (p + 1) % 8;
    end
    return n;
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int base, exp_n, writes;
    reset_n     = 1'b0;
    host_req    = 1'b0;
    host_we     = 1'b0;
    host_addr   = '0;
    host_wdata  = '0;
    clear_start = 1'b0;
    clear_char  = '0;
    repeat (3) @(posedge pixel_clock);
    @(negedge pixel_clock);
    check("rst_character", 0, 32'(character), 32'h20);
    check("rst_ack", 0, 32'(host_ack), 32'd0);
    check("rst_rdata", 0, 32'(host_rdata), 32'd0);
    check("rst_busy", 0, 32'(clear_busy), 32'd0);
    step();
    reset_n = 1'b1;

    // Write then read back cell (row 1, col 1).
    host_op(1'b1, 81, 8'h41, 8'h00, 1'b0);
    host_op(1'b0, 81, 8'h00, 8'h41, 1'b1);

    // Display of that cell, with a host read colliding with the fetch slot.
    jump_to(0, 8);
    push_char(8, 8, 8'h41);
    push_char(8, 15, 8'h41);
    for (int i = 0; i < 16 && vga_hpos != 11'd6; i++) step();
    issue(1'b0, 81, 8'h00, 8'h41, 1'b1, 1'b1);
    wait_ack(40);
    wait_chars(100);

    // Line wrap: last column of row 1, then column 0 of row 2.
    host_op(1'b1, 160, 8'h55, 8'h00, 1'b0);
    host_op(1'b1, 159, 8'h7A, 8'h00, 1'b0);
    jump_to(600, 15);
    push_char(15, 632, 8'h7A);
    push_char(15, 639, 8'h7A);
    push_char(16, 0, 8'h55);
    push_char(16, 7, 8'h55);
    wait_chars(400);

    // Out-of-range accesses.
    host_op(1'b1, 0, 8'h11, 8'h00, 1'b0);
    host_op(1'b1, CELLS, 8'hFF, 8'h00, 1'b1);
    host_op(1'b0, 0, 8'h00, 8'h11, 1'b1);
    host_op(1'b0, CELLS, 8'h00, 8'h00, 1'b1);
    host_op(1'b0, CELLS - 1, 8'h00, 8'h00, 1'b0);

    // Full clear with a host request raised mid-fill.
    step();
    align_nonslot();
    clear_char  = 8'h2E;
    clear_start = 1'b1;
    exp_n = clear_model(int'(vga_hpos[2:0] + 3'd1));
    base  = busy_cnt;
    step();
    clear_start = 1'b0;
    check("busy_after_start", 0, 32'(clear_busy), 32'd1);
    repeat (20) step();
    issue(1'b0, 0, 8'h00, 8'h2E, 1'b1, 1'b0);
    wait_ack(8000);
    check("clear_cycles", 0, busy_cnt - base, exp_n);
    host_op(1'b0, CELLS - 1, 8'h00, 8'h2E, 1'b1);

    // Reset while the fill counter sits at 100.
    host_op(1'b1, 200, 8'h99, 8'h00, 1'b0);
    step();
    align_nonslot();
    clear_char  = 8'h3C;
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    writes = 0;
    while (writes < 100) begin
      if (vga_hpos[2:0] != FETCH_PHASE) writes++;
      step();
    end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    @(negedge pixel_clock);
    check("abort_busy", 0, 32'(clear_busy), 32'd0);
    check("abort_character", 0, 32'(character), 32'h20);
    check("abort_ack", 0, 32'(host_ack), 32'd0);
    host_op(1'b0, 0, 8'h00, 8'h3C, 1'b1);
    host_op(1'b0, 99, 8'h00, 8'h3C, 1'b1);
    host_op(1'b0, 100, 8'h00, 8'h2E, 1'b1);
    host_op(1'b0, 200, 8'h00, 8'h99, 1'b1);

    repeat (4) step();
    if (hq.size() != 0) begin
      vectors++;
      fails++;
      $display("FAIL pending_acks: got %0d outstanding, expected 0", hq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
